// File: rtl/seg7_capture_decode.sv
// seg7_capture_decode: settle, decode and store per-digit codes from a multiplexed active-low 7-segment bus
// Ports: clk, reset (async, active-high); seg_n (g..a, active-low), dig_sel (one-hot strobe, 0 = blanked);
//   bcd_out (digit i at [4i+3:4i]), digit_valid (sticky legal flag), upd/upd_idx (write pulse + digit),
//   err (illegal capture pulse), err_cnt (saturating err count).
// Define SEG7_HEX_EN to accept hex letter patterns A..F as codes 10..15.
module seg7_capture_decode #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    upd,
  output logic [2:0]              upd_idx,
  output logic                    err,
  output logic [7:0]              err_cnt
);
  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} state_t;
  state_t state_q, state_d;
  logic [6:0] seg_q;
  logic [NUM_DIGITS-1:0] sel_q;
  logic [6+NUM_DIGITS:0] prev_q;
  logic [7:0] cnt_q, cnt_d, cnt_inc, err_cnt_q, err_cnt_d;
  logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0] valid_q, valid_d;
  logic upd_q, upd_d, err_q, err_d, go, blank, changed, onehot, legal;
  logic [2:0] idx_q, idx_d;
  logic [4:0] dec;
  int di;
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h40: decode = 5'h10;
      7'h79: decode = 5'h11;
      7'h24: decode = 5'h12;
      7'h30: decode = 5'h13;
      7'h19: decode = 5'h14;
      7'h12: decode = 5'h15;
      7'h02: decode = 5'h16;
      7'h78: decode = 5'h17;
      7'h00: decode = 5'h18;
      7'h10: decode = 5'h19;
`ifdef SEG7_HEX_EN
      7'h08: decode = 5'h1A;
      7'h03: decode = 5'h1B;
      7'h46: decode = 5'h1C;
      7'h21: decode = 5'h1D;
      7'h06: decode = 5'h1E;
      7'h0E: decode = 5'h1F;
`endif
      default: decode = 5'h00;
    endcase
  endfunction
  always_comb begin
    blank   = sel_q == '0;
    changed = {seg_q, sel_q} != prev_q;
    cnt_inc = cnt_q + 8'd1;
    state_d = state_q;
    cnt_d   = cnt_q;
    go      = 1'b0;
    case (state_q)
      IDLE: if (!blank) begin
        state_d = SETTLE;
        cnt_d   = 8'd1;
      end
      SETTLE: if (blank) state_d = IDLE;
        else if (changed) cnt_d = 8'd1;
        else begin
          cnt_d = cnt_inc;
          if (cnt_inc == 8'(STABLE_CYCLES)) begin
            state_d = CAPTURE;
            go      = 1'b1;
          end
        end
      // CAPTURE tracks changes like HOLD so a change in the capture cycle is not missed
      default: if (blank) state_d = IDLE;
        else if (changed) begin
          state_d = SETTLE;
          cnt_d   = 8'd1;
        end else state_d = HOLD;
    endcase
  end
  always_comb begin
    dec    = decode(seg_q);
    onehot = $onehot(sel_q);
    legal  = onehot && dec[4];
    di     = 0;
    for (int i = 0; i < NUM_DIGITS; i++) if (sel_q[i]) di = i;
    bcd_d   = bcd_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    upd_d   = go && legal;
    err_d   = go && !legal;
    if (go && onehot) begin
      valid_d[di] = dec[4];
      if (dec[4]) bcd_d[di*4 +: 4] = dec[3:0];
    end
    if (upd_d) idx_d = 3'(di);
    err_cnt_d = (err_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_q     <= 7'h7F;
      sel_q     <= '0;
      prev_q    <= '0;
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      bcd_q     <= '0;
      valid_q   <= '0;
      upd_q     <= 1'b0;
      err_q     <= 1'b0;
      idx_q     <= 3'd0;
      err_cnt_q <= 8'd0;
    end else begin
      seg_q     <= seg_n;
      sel_q     <= dig_sel;
      prev_q    <= {seg_q, sel_q};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      valid_q   <= valid_d;
      upd_q     <= upd_d;
      err_q     <= err_d;
      idx_q     <= idx_d;
      err_cnt_q <= err_cnt_d;
    end
  end
  assign bcd_out     = bcd_q;
  assign digit_valid = valid_q;
  assign upd         = upd_q;
  assign upd_idx     = idx_q;
  assign err         = err_q;
  assign err_cnt     = err_cnt_q;
endmodule
